// File: rtl/mem_port_arbiter.sv
// Arbiter between instruction fetch and the data-memory stage for the single-ported
// memory: one fixed-latency access at a time, MEM priority with IF starvation relief.
module mem_port_arbiter #(
    parameter int IADDR_W    = 8,
    parameter int DADDR_W    = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               if_req,
    input  logic [IADDR_W-1:0] if_addr,
    output logic               if_ready,
    output logic [DATA_W-1:0]  if_instr,
    input  logic               dm_read,
    input  logic               dm_write,
    input  logic [DADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0]  dm_wdata,
    output logic               dm_ready,
    output logic [DATA_W-1:0]  dm_rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [DADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               stall_if,
    output logic               stall_mem,
    output logic               busy,
    output logic               err_rw
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]       state_r;
    logic [LAT_W-1:0] lat_cnt_r;
    logic [STV_W-1:0] starve_cnt_r;
    logic             grant_if_r;
    logic             grant_rd_r;
    logic             dm_req_s;
    logic             pick_if_s;
    logic             pick_mem_s;

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = (dm_read | dm_write) & ~dm_ready;
    assign busy      = (state_r != ST_IDLE);

    // Arbitration decision, only meaningful while idle; MEM wins unless IF is starved
    always_comb begin
        dm_req_s   = dm_read | dm_write;
        pick_if_s  = 1'b0;
        pick_mem_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (if_req && ((starve_cnt_r == STV_MAX) || !dm_req_s)) begin
                pick_if_s = 1'b1;
            end else if (dm_req_s) begin
                pick_mem_s = 1'b1;
            end else begin
                pick_if_s  = 1'b0;
                pick_mem_s = 1'b0;
            end
        end else begin
            pick_if_s  = 1'b0;
            pick_mem_s = 1'b0;
        end
    end

    // Access sequencer, starvation tracking and all registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            lat_cnt_r    <= '0;
            starve_cnt_r <= '0;
            grant_if_r   <= 1'b0;
            grant_rd_r   <= 1'b0;
            if_ready     <= 1'b0;
            dm_ready     <= 1'b0;
            if_instr     <= '0;
            dm_rdata     <= '0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            err_rw       <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            if (dm_read && dm_write) begin
                err_rw <= 1'b1;
            end
            // Counter only measures an unbroken stretch of IF waiting behind MEM
            if (!if_req || pick_if_s) begin
                starve_cnt_r <= '0;
            end else if (pick_mem_s && (starve_cnt_r != STV_MAX)) begin
                starve_cnt_r <= starve_cnt_r + STV_W'(1);
            end
            case (state_r)
                ST_IDLE: begin
                    if (pick_if_s) begin
                        grant_if_r <= 1'b1;
                        grant_rd_r <= 1'b1;
                        mem_addr   <= DADDR_W'(if_addr);
                        mem_wdata  <= '0;
                        mem_we     <= 1'b0;
                        mem_en     <= 1'b1;
                        lat_cnt_r  <= '0;
                        state_r    <= ST_ACCESS;
                    end else if (pick_mem_s) begin
                        // A simultaneous read+write request is serviced as a write
                        grant_if_r <= 1'b0;
                        grant_rd_r <= ~dm_write;
                        mem_addr   <= dm_addr;
                        mem_wdata  <= dm_wdata;
                        mem_we     <= dm_write;
                        mem_en     <= 1'b1;
                        lat_cnt_r  <= '0;
                        state_r    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (lat_cnt_r == LAT_LAST) begin
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        state_r <= ST_DONE;
                        if (grant_if_r) begin
                            if_instr <= mem_rdata;
                            if_ready <= 1'b1;
                        end else begin
                            dm_ready <= 1'b1;
                            if (grant_rd_r) begin
                                dm_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        lat_cnt_r <= lat_cnt_r + LAT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default parameters, MEM_LAT=2,
// STARVE_MAX=4) with a small address-decoded memory model.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_ready;
    logic [15:0] if_instr;
    logic        dm_read;
    logic        dm_write;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_ready;
    logic [15:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic        busy;
    logic        err_rw;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_instr  (if_instr),
        .dm_read   (dm_read),
        .dm_write  (dm_write),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ready  (dm_ready),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .busy      (busy),
        .err_rw    (err_rw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: two fixed words, otherwise low address byte followed by 8'h5A
    always_comb begin
        case (mem_addr)
            16'h0004: mem_rdata = 16'h1234;
            16'h0010: mem_rdata = 16'hCAFE;
            default:  mem_rdata = {mem_addr[7:0], 8'h5A};
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; if_req = 1'b1; if_addr = 8'h04;
        for (int c = 1; c <= 2; c++) begin
            tick();
            checks++;
            if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en c%0d: got %b expected 0", c, mem_en); end
        end
        checks++;
        if ({mem_we, if_ready, dm_ready, busy, err_rw, stall_mem} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 000000", {mem_we, if_ready, dm_ready, busy, err_rw, stall_mem});
        end
        checks++;
        if ({if_instr, dm_rdata, mem_addr, mem_wdata} !== 64'h0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", {if_instr, dm_rdata, mem_addr, mem_wdata});
        end
        checks++;
        if (stall_if !== 1'b1) begin errors++; $display("FAIL reset_stall_if: got %b expected 1", stall_if); end
        if_req = 1'b0; reset = 1'b1;
        tick();
        checks++;
        if ({busy, mem_en} !== 2'b00) begin errors++; $display("FAIL reset_release_idle: got %b expected 00", {busy, mem_en}); end
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 8'h04;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (mem_en !== (c == 1 || c == 2)) begin errors++; $display("FAIL fetch_mem_en c%0d: got %b", c, mem_en); end
            checks++;
            if (if_ready !== (c == 3)) begin errors++; $display("FAIL fetch_if_ready c%0d: got %b", c, if_ready); end
            if (c <= 2) begin
                checks++;
                if (mem_addr !== 16'h0004 || mem_we !== 1'b0) begin
                    errors++; $display("FAIL fetch_addr c%0d: got %h/%b expected 0004/0", c, mem_addr, mem_we);
                end
            end
            if (c >= 3) begin
                checks++;
                if (if_instr !== 16'h1234) begin errors++; $display("FAIL fetch_instr c%0d: got %h expected 1234", c, if_instr); end
            end
            if (c == 3) if_req = 1'b0;
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL fetch_idle: got %b expected 0", busy); end
    endtask

    task automatic test_collision();
        if_req = 1'b1; if_addr = 8'h08; dm_read = 1'b1; dm_addr = 16'h0010;
        for (int c = 1; c <= 7; c++) begin
            tick();
            checks++;
            if (stall_if !== (c < 7)) begin errors++; $display("FAIL coll_stall_if c%0d: got %b", c, stall_if); end
            checks++;
            if (mem_en !== (c == 1 || c == 2 || c == 5 || c == 6)) begin errors++; $display("FAIL coll_mem_en c%0d: got %b", c, mem_en); end
            checks++;
            if (dm_ready !== (c == 3) || if_ready !== (c == 7)) begin
                errors++; $display("FAIL coll_ready c%0d: got dm=%b if=%b", c, dm_ready, if_ready);
            end
            if (c == 1) begin
                checks++;
                if (mem_addr !== 16'h0010) begin errors++; $display("FAIL coll_mem_first: got %h expected 0010", mem_addr); end
            end
            if (c == 5) begin
                checks++;
                if (mem_addr !== 16'h0008) begin errors++; $display("FAIL coll_if_addr: got %h expected 0008", mem_addr); end
            end
            if (c == 3) begin
                checks++;
                if (dm_rdata !== 16'hCAFE) begin errors++; $display("FAIL coll_dm_rdata: got %h expected cafe", dm_rdata); end
                dm_read = 1'b0;
            end
            if (c == 7) begin
                checks++;
                if (if_instr !== 16'h085A) begin errors++; $display("FAIL coll_if_instr: got %h expected 085a", if_instr); end
                if_req = 1'b0;
            end
        end
        tick();
    endtask

    task automatic test_starvation();
        bit exp_if [10];
        int n;
        int cyc;
        for (int k = 0; k < 10; k++) exp_if[k] = ((k % 5) == 4);
        n = 0; cyc = 0;
        if_addr = 8'h0C; dm_addr = 16'h0030; if_req = 1'b1; dm_read = 1'b1;
        while (n < 10 && cyc < 100) begin
            tick();
            cyc++;
            if (dm_ready && if_ready) begin
                checks++; errors++;
                $display("FAIL starve_both_ready: got both ready in cycle %0d expected one", cyc);
            end else if (dm_ready || if_ready) begin
                checks++;
                if (if_ready !== exp_if[n]) begin
                    errors++; $display("FAIL starve_order #%0d: got if_ready=%b expected %b", n, if_ready, exp_if[n]);
                end
                if (dm_ready) dm_read = 1'b0;
                else if_req = 1'b0;
                n++;
            end else begin
                dm_read = 1'b1; if_req = 1'b1;
            end
        end
        checks++;
        if (n != 10) begin errors++; $display("FAIL starve_timeout: got %0d completions expected 10", n); end
        if_req = 1'b0; dm_read = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_write_err();
        checks++;
        if (err_rw !== 1'b0) begin errors++; $display("FAIL err_before: got %b expected 0", err_rw); end
        dm_read = 1'b1; dm_write = 1'b1; dm_addr = 16'h0020; dm_wdata = 16'hBEEF;
        for (int c = 1; c <= 6; c++) begin
            tick();
            checks++;
            if (mem_we !== (c <= 2) || mem_en !== (c <= 2)) begin
                errors++; $display("FAIL wr_we c%0d: got we=%b en=%b", c, mem_we, mem_en);
            end
            checks++;
            if (dm_ready !== (c == 3)) begin errors++; $display("FAIL wr_ready c%0d: got %b", c, dm_ready); end
            checks++;
            if (err_rw !== 1'b1) begin errors++; $display("FAIL wr_err_sticky c%0d: got %b expected 1", c, err_rw); end
            if (c <= 2) begin
                checks++;
                if (mem_wdata !== 16'hBEEF || mem_addr !== 16'h0020) begin
                    errors++; $display("FAIL wr_data c%0d: got %h@%h expected beef@0020", c, mem_wdata, mem_addr);
                end
            end
            if (c == 3) begin
                checks++;
                if (dm_rdata !== 16'h305A) begin errors++; $display("FAIL wr_rdata_kept: got %h expected 305a", dm_rdata); end
                dm_read = 1'b0; dm_write = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        if_req = 1'b1; if_addr = 8'h14;
        tick();
        checks++;
        if (mem_en !== 1'b1) begin errors++; $display("FAIL rmid_start: got %b expected 1", mem_en); end
        reset = 1'b0;
        tick();
        checks++;
        if ({mem_en, mem_we, busy, if_ready, err_rw} !== 5'b0) begin
            errors++; $display("FAIL rmid_abort: got %b expected 00000", {mem_en, mem_we, busy, if_ready, err_rw});
        end
        reset = 1'b1;
        for (int c = 3; c <= 5; c++) begin
            tick();
            checks++;
            if (mem_en !== (c <= 4) || if_ready !== (c == 5)) begin
                errors++; $display("FAIL rmid_regrant c%0d: got en=%b rdy=%b", c, mem_en, if_ready);
            end
        end
        checks++;
        if (if_instr !== 16'h145A) begin errors++; $display("FAIL rmid_instr: got %h expected 145a", if_instr); end
        if_req = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0; if_req = 1'b0; if_addr = 8'h00;
        dm_read = 1'b0; dm_write = 1'b0; dm_addr = 16'h0000; dm_wdata = 16'h0000;
        test_reset();
        test_fetch();
        test_collision();
        test_starvation();
        test_write_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
